uart_rx: RTL and testbench

- Serial receive stage of the MIPS UART peripheral.
- Sits between the baud generator and the memory-mapped UART register block.
- Samples the asynchronous `rx` line using the oversampled baud tick, deframes 8N1 characters (LSB first), and queues received bytes in a small first-word-fall-through FIFO for the CPU to read.
- Reports framing errors and overruns as sticky flags.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART: oversampled tick and serial line in,
// FIFO head/status and sticky error flags out, pop and error-clear controls in.
// slave = receiver (uart_rx); master = consumer (register block / bench).
interface uart_rx_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 tick;
  logic                 rx;
  logic                 rd_en;
  logic                 clr_err;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rx_valid;
  logic                 fifo_full;
  logic [CW-1:0]        count;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output tick, rx, rd_en, clr_err,
    input  rd_data, rx_valid, fifo_full, count, frame_err, overrun
  );

  modport slave (
    input  tick, rx, rd_en, clr_err,
    output rd_data, rx_valid, fifo_full, count, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled deframing FSM, FWFT byte FIFO.
// Latency: byte visible (rx_valid/count) on the edge after the stop-bit sample tick.
// Backpressure: none on the line; a full FIFO drops the byte and sets overrun (unless popped same cycle).
// Ports: clk, rst (async active-low), bus (uart_rx_if.slave: tick/rx/rd_en/clr_err in; data/status/flags out).
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  // Synchronizer
  logic rx_meta_q, rx_s_q;

  // Deframer
  state_t               state_q, state_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push, frame_set, ovr_set;

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q, count_w;
  logic                 full, empty, pop;

  // Flags
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;

  assign count_w = wr_ptr_q - rd_ptr_q;
  assign full    = (count_w == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_w == '0);
  assign pop     = bus.rd_en & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sc_q    <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_set = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      IDLE: begin
        // Falling edge detection runs every clk, independent of tick.
        if (!rx_s_q) begin
          state_d = START;
          sc_d    = '0;
        end
      end
      START: begin
        if (bus.tick) begin
          if (sc_q == SCW'(OVERSAMPLE/2 - 1)) begin
            sc_d  = '0;
            idx_d = '0;
            state_d = rx_s_q ? IDLE : DATA;  // high at mid start bit = glitch
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.tick) begin
          if (sc_q == SCW'(OVERSAMPLE - 1)) begin
            shreg_d[idx_q] = rx_s_q;
            sc_d = '0;
            if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
            else                             idx_d   = idx_q + 1'b1;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.tick) begin
          if (sc_q == SCW'(OVERSAMPLE - 1)) begin
            sc_d = '0;
            if (rx_s_q) begin
              // A pop in the same cycle frees a slot, so a full FIFO still accepts.
              if (!full || pop) push    = 1'b1;
              else              ovr_set = 1'b1;
              state_d = IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = BRK;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      BRK: begin
        // Hold off until the line returns high so a held-low line is not re-framed.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Set has priority over clear.
  assign frame_err_d = frame_set | (frame_err_q & ~bus.clr_err);
  assign overrun_d   = ovr_set   | (overrun_q   & ~bus.clr_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rd_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.rx_valid  = ~empty;
  assign bus.fifo_full = full;
  assign bus.count     = count_w;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at 16 ticks/bit, tick every 4 clk.
// Covers reset, latency, glitch, framing error/break, overrun, push+pop when full, mid-frame reset.
// Inputs change on negedge; outputs are sampled #1 after the tick edge.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [1:0] tcnt = 2'd0;

  uart_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // One-clk tick every 4 clocks.
  initial bus.tick = 1'b0;
  always @(negedge clk) begin
    tcnt     <= tcnt + 2'd1;
    bus.tick <= (tcnt == 2'd3);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    bus.rx = b;
    wait_ticks(n);
  endtask

  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d);
    send_bit(1'b1, 16);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, {24'd0, bus.rd_data}, {24'd0, exp});
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx = 1'b1; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_rd_data",   {24'd0, bus.rd_data}, 32'h0);
    check("rst_rx_valid",  {31'd0, bus.rx_valid}, 32'd0);
    check("rst_fifo_full", {31'd0, bus.fifo_full}, 32'd0);
    check("rst_count",     {29'd0, bus.count}, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_overrun",   {31'd0, bus.overrun}, 32'd0);
    @(negedge clk); rst = 1'b1;
    wait_ticks(4);

    // Single frame 0x55 with latency check around the stop sample tick.
    send_head(8'h55);
    @(negedge clk); bus.rx = 1'b1;
    wait_ticks(7); #1;
    check("f1_pre_count", {29'd0, bus.count}, 32'd0);
    wait_ticks(1); #1;
    check("f1_valid",     {31'd0, bus.rx_valid}, 32'd1);
    check("f1_data",      {24'd0, bus.rd_data}, 32'h55);
    check("f1_count",     {29'd0, bus.count}, 32'd1);
    check("f1_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("f1_overrun",   {31'd0, bus.overrun}, 32'd0);
    wait_ticks(8);
    pop_check("f1_pop", 8'h55);

    // Glitch: 4 ticks low.
    send_bit(1'b0, 4);
    send_bit(1'b1, 20); #1;
    check("gl_count",     {29'd0, bus.count}, 32'd0);
    check("gl_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("gl_overrun",   {31'd0, bus.overrun}, 32'd0);

    // Framing error on 0xA3, line held low, then a good 0x3C.
    send_head(8'hA3);
    send_bit(1'b0, 40); #1;
    check("fe_flag",  {31'd0, bus.frame_err}, 32'd1);
    check("fe_count", {29'd0, bus.count}, 32'd0);
    send_bit(1'b1, 16);
    send_frame(8'h3C); #1;
    check("fe_next_count", {29'd0, bus.count}, 32'd1);
    pop_check("fe_next_data", 8'h3C);
    @(negedge clk); bus.clr_err = 1'b1;
    @(negedge clk); bus.clr_err = 1'b0;
    check("fe_clr", {31'd0, bus.frame_err}, 32'd0);

    // Overrun: five frames, no reads.
    for (int i = 1; i <= 5; i++) send_frame(i[7:0]);
    #1;
    check("ov_count",   {29'd0, bus.count}, 32'd4);
    check("ov_full",    {31'd0, bus.fifo_full}, 32'd1);
    check("ov_overrun", {31'd0, bus.overrun}, 32'd1);
    pop_check("ov_pop1", 8'h01);
    pop_check("ov_pop2", 8'h02);
    pop_check("ov_pop3", 8'h03);
    pop_check("ov_pop4", 8'h04);
    check("ov_empty", {31'd0, bus.rx_valid}, 32'd0);
    @(negedge clk); bus.rd_en = 1'b1;
    @(negedge clk); bus.rd_en = 1'b0;
    check("ov_pop_empty_count", {29'd0, bus.count}, 32'd0);
    @(negedge clk); bus.clr_err = 1'b1;
    @(negedge clk); bus.clr_err = 1'b0;
    check("ov_clr", {31'd0, bus.overrun}, 32'd0);

    // Push and pop together while full.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + i[7:0]);
    #1;
    check("sp_full", {31'd0, bus.fifo_full}, 32'd1);
    send_head(8'h14);
    @(negedge clk); bus.rx = 1'b1;
    wait_ticks(7);
    repeat (3) @(posedge clk);
    @(negedge clk); bus.rd_en = 1'b1;   // covers exactly the stop-sample tick edge
    @(posedge clk);
    @(negedge clk); bus.rd_en = 1'b0;
    check("sp_count",   {29'd0, bus.count}, 32'd4);
    check("sp_overrun", {31'd0, bus.overrun}, 32'd0);
    wait_ticks(8);
    pop_check("sp_pop1", 8'h11);
    pop_check("sp_pop2", 8'h12);
    pop_check("sp_pop3", 8'h13);
    pop_check("sp_pop4", 8'h14);

    // Reset mid-frame with a flag set and a byte queued.
    send_head(8'h00);
    send_bit(1'b0, 20);
    send_bit(1'b1, 16);
    send_frame(8'h42); #1;
    check("mr_pre_count", {29'd0, bus.count}, 32'd1);
    check("mr_pre_ferr",  {31'd0, bus.frame_err}, 32'd1);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 8);                  // mid data bit 3
    @(negedge clk); rst = 1'b0; bus.rx = 1'b1;
    #1;
    check("mr_valid",   {31'd0, bus.rx_valid}, 32'd0);
    check("mr_count",   {29'd0, bus.count}, 32'd0);
    check("mr_ferr",    {31'd0, bus.frame_err}, 32'd0);
    check("mr_overrun", {31'd0, bus.overrun}, 32'd0);
    check("mr_rd_data", {24'd0, bus.rd_data}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_ticks(20);
    send_frame(8'h7E); #1;
    check("mr_after_count", {29'd0, bus.count}, 32'd1);
    check("mr_after_data",  {24'd0, bus.rd_data}, 32'h7E);
    check("mr_after_ferr",  {31'd0, bus.frame_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
